m_store_buffer: RTL and testbench

Store-side counterpart of the M-stage load extender. It accepts committed stores from the M stage and converts each store type (sw/sh/sb) into a word-aligned address, replicated write data and a 4-bit byte enable. Misaligned stores are flagged as AdES. Legal stores are queued in a small FIFO and drained to the data bus with a req/ack handshake, stalling the pipeline when the FIFO is full and flagging loads that hit a pending store word.

---
 rtl/m_store_buffer.sv | 171 +++++++++++++++++
 tb/tb_m_store_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_store_buffer.sv
// M-stage store buffer: encodes sw/sh/sb into word address, replicated data and
// byte enables, queues legal stores and drains them to the data bus over req/ack.
module m_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_stall,
    output logic        st_exc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        m_req,
    input  logic        m_ack,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic        drained
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] TYPE_SW = 3'd1;
    localparam logic [2:0] TYPE_SH = 3'd2;
    localparam logic [2:0] TYPE_SB = 3'd3;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [29:0] addr_q   [DEPTH];
    logic [29:0] addr_d   [DEPTH];
    logic [31:0] wdata_q  [DEPTH];
    logic [31:0] wdata_d  [DEPTH];
    logic [3:0]  byteen_q [DEPTH];
    logic [3:0]  byteen_d [DEPTH];

    logic        enc_legal;
    logic        enc_misaligned;
    logic [31:0] enc_wdata;
    logic [3:0]  enc_byteen;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // The two low load-address bits never matter: hazards are tracked per word.
    logic [1:0] unused_ld_bits;
    assign unused_ld_bits = ld_addr[1:0];

    always_comb begin
        enc_legal      = 1'b0;
        enc_misaligned = 1'b0;
        enc_wdata      = '0;
        enc_byteen     = '0;
        case (st_type)
            TYPE_SW: begin
                enc_legal      = (st_addr[1:0] == 2'b00);
                enc_misaligned = ~enc_legal;
                enc_wdata      = st_wdata;
                enc_byteen     = 4'b1111;
            end
            TYPE_SH: begin
                enc_legal      = ~st_addr[0];
                enc_misaligned = st_addr[0];
                enc_wdata      = {2{st_wdata[15:0]}};
                enc_byteen     = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            TYPE_SB: begin
                enc_legal      = 1'b1;
                enc_wdata      = {4{st_wdata[7:0]}};
                enc_byteen     = 4'b0001 << st_addr[1:0];
            end
            default: begin
                enc_legal      = 1'b0;
                enc_misaligned = 1'b0;
            end
        endcase
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Stall looks only at the registered count; a same-cycle pop does not make room.
    assign st_exc   = st_valid & enc_misaligned;
    assign st_stall = st_valid & enc_legal & full;
    assign push     = st_valid & enc_legal & ~full;
    assign pop      = m_ack & ~empty;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end

        if (push) begin
            valid_d[wr_ptr_q]  = 1'b1;
            addr_d[wr_ptr_q]   = st_addr[31:2];
            wdata_d[wr_ptr_q]  = enc_wdata;
            byteen_d[wr_ptr_q] = enc_byteen;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        byteen_q <= byteen_d;
    end

    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
        ld_hazard = ld_hazard & ld_valid;
    end

    always_comb begin
        m_req    = ~empty;
        m_addr   = '0;
        m_wdata  = '0;
        m_byteen = '0;
        if (!empty) begin
            m_addr   = {addr_q[rd_ptr_q], 2'b00};
            m_wdata  = wdata_q[rd_ptr_q];
            m_byteen = byteen_q[rd_ptr_q];
        end
    end

    assign drained = empty;

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: directed test-plan steps and a random stream, all
// compared every cycle against a queue-based model of the store buffer.
module tb_m_store_buffer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [2:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_stall;
    logic        st_exc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        m_req;
    logic        m_ack;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        drained;

    int nchk = 0;
    int nerr = 0;
    int npop = 0;

    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [3:0]  qb[$];

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_type   (st_type),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_stall  (st_stall),
        .st_exc    (st_exc),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .m_req     (m_req),
        .m_ack     (m_ack),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byteen  (m_byteen),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store-type rules expressed directly as address arithmetic.
    task automatic model_enc(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                             output bit legal, output bit exc,
                             output logic [31:0] wd, output logic [3:0] be);
        legal = 0;
        exc   = 0;
        wd    = '0;
        be    = '0;
        if (t == 3'd1) begin
            legal = (a % 4 == 0);
            exc   = !legal;
            wd    = d;
            be    = 4'hF;
        end else if (t == 3'd2) begin
            legal = (a % 2 == 0);
            exc   = !legal;
            wd    = 32'(d[15:0]) * 32'h0001_0001;
            be    = (a % 4 >= 2) ? 4'hC : 4'h3;
        end else if (t == 3'd3) begin
            legal = 1;
            wd    = 32'(d[7:0]) * 32'h0101_0101;
            be    = 4'(1 << (a % 4));
        end
    endtask

    task automatic tick();
        bit legal, exc, hz, full, do_push, do_pop, do_rst;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] new_addr;
        @(negedge clk);
        model_enc(st_type, st_addr, st_wdata, legal, exc, wd, be);
        full = (qa.size() == DEPTH);
        hz = 0;
        foreach (qa[i]) if ((qa[i] >> 2) == (ld_addr >> 2)) hz = 1;
        chk("st_exc",    32'(st_exc),    32'(st_valid & exc));
        chk("st_stall",  32'(st_stall),  32'(st_valid & legal & full));
        chk("ld_hazard", 32'(ld_hazard), 32'(ld_valid & hz));
        chk("m_req",     32'(m_req),     32'(qa.size() != 0));
        chk("drained",   32'(drained),   32'(qa.size() == 0));
        chk("m_addr",    m_addr,         (qa.size() != 0) ? qa[0] : 32'h0);
        chk("m_wdata",   m_wdata,        (qa.size() != 0) ? qd[0] : 32'h0);
        chk("m_byteen",  32'(m_byteen),  (qa.size() != 0) ? 32'(qb[0]) : 32'h0);
        do_rst   = !reset;
        do_push  = st_valid && legal && !full;
        do_pop   = m_ack && (qa.size() != 0);
        new_addr = (st_addr / 4) * 4;
        @(posedge clk);
        #1;
        if (do_rst) begin
            qa.delete();
            qd.delete();
            qb.delete();
        end else begin
            if (do_pop) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
                void'(qb.pop_front());
                npop++;
            end
            if (do_push) begin
                qa.push_back(new_addr);
                qd.push_back(wd);
                qb.push_back(be);
            end
        end
    endtask

    task automatic set_st(input bit v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_type  = t;
        st_addr  = a;
        st_wdata = d;
    endtask

    initial begin
        reset    = 1'b0;
        m_ack    = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        set_st(0, 3'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        tick();
        reset = 1'b1;
        #2;
        chk("rst_drained", 32'(drained), 32'h1);
        chk("rst_m_req",   32'(m_req),   32'h0);

        // sh to 0x1002 with ack held
        m_ack = 1'b1;
        set_st(1, 3'd2, 32'h0000_1002, 32'h1234_ABCD);
        tick();
        set_st(0, 3'd0, 32'h0, 32'h0);
        #2;
        chk("sh_req",    32'(m_req),    32'h1);
        chk("sh_addr",   m_addr,        32'h0000_1000);
        chk("sh_wdata",  m_wdata,       32'hABCD_ABCD);
        chk("sh_byteen", 32'(m_byteen), 32'hC);
        tick();
        #2;
        chk("sh_drained", 32'(drained), 32'h1);

        // sb to 0x2003, then a misaligned sw
        set_st(1, 3'd3, 32'h0000_2003, 32'h0000_005A);
        tick();
        set_st(1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF);
        #2;
        chk("sb_byteen", 32'(m_byteen), 32'h8);
        chk("sb_wdata",  m_wdata,       32'h5A5A_5A5A);
        chk("ades_exc",  32'(st_exc),   32'h1);
        chk("ades_stall", 32'(st_stall), 32'h0);
        tick();
        set_st(0, 3'd0, 32'h0, 32'h0);
        #2;
        chk("ades_noreq", 32'(m_req), 32'h0);
        tick();

        // full FIFO: three back-to-back sw with no ack
        m_ack = 1'b0;
        set_st(1, 3'd1, 32'h0000_0100, 32'h1111_1111);
        tick();
        set_st(1, 3'd1, 32'h0000_0104, 32'h2222_2222);
        tick();
        set_st(1, 3'd1, 32'h0000_0108, 32'h3333_3333);
        #2;
        chk("full_stall", 32'(st_stall), 32'h1);
        tick();
        m_ack = 1'b1;
        #2;
        chk("full_pop_stall", 32'(st_stall), 32'h1);
        chk("full_head1",     m_addr,        32'h0000_0100);
        tick();
        m_ack = 1'b0;
        #2;
        chk("full_accept", 32'(st_stall), 32'h0);
        chk("full_head2",  m_addr,        32'h0000_0104);
        tick();
        set_st(0, 3'd0, 32'h0, 32'h0);
        m_ack = 1'b1;
        tick();
        #2;
        chk("full_head3", m_addr, 32'h0000_0108);
        tick();
        #2;
        chk("full_drained", 32'(drained), 32'h1);

        // load hazard against a pending store word
        m_ack = 1'b0;
        set_st(1, 3'd1, 32'h0000_3004, 32'hCAFE_F00D);
        tick();
        set_st(0, 3'd0, 32'h0, 32'h0);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3006;
        #2;
        chk("hz_match", 32'(ld_hazard), 32'h1);
        tick();
        ld_addr = 32'h0000_3008;
        #2;
        chk("hz_other_word", 32'(ld_hazard), 32'h0);
        tick();
        m_ack   = 1'b1;
        ld_addr = 32'h0000_3006;
        tick();
        m_ack = 1'b0;
        #2;
        chk("hz_after_ack", 32'(ld_hazard), 32'h0);
        tick();
        ld_valid = 1'b0;

        // reset while full and being acked
        set_st(1, 3'd1, 32'h0000_4000, 32'hAAAA_0001);
        tick();
        set_st(1, 3'd1, 32'h0000_4004, 32'hAAAA_0002);
        tick();
        set_st(0, 3'd0, 32'h0, 32'h0);
        #2;
        chk("pre_rst_req", 32'(m_req), 32'h1);
        reset = 1'b0;
        m_ack = 1'b1;
        tick();
        reset = 1'b1;
        m_ack = 1'b0;
        #2;
        chk("post_rst_req",    32'(m_req),    32'h0);
        chk("post_rst_addr",   m_addr,        32'h0);
        chk("post_rst_wdata",  m_wdata,       32'h0);
        chk("post_rst_byteen", 32'(m_byteen), 32'h0);
        chk("post_rst_drain",  32'(drained),  32'h1);
        tick();

        // random stream across all store types and ack patterns
        for (int n = 0; n < 600; n++) begin
            set_st($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                   32'h0000_5000 + 32'($urandom_range(0, 31)), $urandom);
            m_ack    = $urandom_range(0, 1) != 0;
            ld_valid = $urandom_range(0, 1) != 0;
            ld_addr  = 32'h0000_5000 + 32'($urandom_range(0, 31));
            tick();
        end
        set_st(0, 3'd0, 32'h0, 32'h0);
        ld_valid = 1'b0;
        m_ack    = 1'b1;
        for (int n = 0; n < DEPTH + 2; n++) tick();
        #2;
        chk("final_drained", 32'(drained), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
